// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
// Holds the arbiter state encoding, error-bit indices and the watchdog width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_W       = 2;

  // A disabled watchdog (timeout 0) still keeps a 1-bit counter so widths stay legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating busy-cycle counter: cleared on issue, counts while enabled, flags TIMEOUT.
// A TIMEOUT of 0 holds the counter at 0 and never raises the flag.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data load/store.
// Latches request pulses per side, issues one transaction at a time (data first), routes responses back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INST_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_valid,
  output logic [INST_W-1:0] o_i_inst,
  input  logic              i_d_read,
  input  logic              i_d_write,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_valid,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic [ERR_W-1:0]  o_err
);

  arb_state_e        state_q, state_d;

  logic              i_pend_q, i_pend_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic              d_pend_q, d_pend_d;
  logic              d_we_q, d_we_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_valid_q, i_valid_d;
  logic [INST_W-1:0] i_inst_q, i_inst_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              wd_clr, wd_hit;
  logic              busy, done, done_i, done_d;
  logic              occ_i, occ_d, d_pulse, i_acc, d_acc;
  logic              i_avail, d_avail, can_issue;
  logic [ADDR_W-1:0] i_sel_addr, d_sel_addr;
  logic              d_sel_we;
  logic [DATA_W-1:0] d_sel_wdata;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (wd_clr),
    .en_i   (busy),
    .hit_o  (wd_hit)
  );

  // A watchdog hit completes the transaction exactly like a memory response.
  assign busy    = (state_q != IDLE);
  assign done    = busy && (i_m_valid || wd_hit);
  assign done_i  = done && (state_q == BUSY_I);
  assign done_d  = done && (state_q == BUSY_D);

  // A side is occupied if pending, or in flight and not completing this cycle.
  assign occ_i   = i_pend_q || ((state_q == BUSY_I) && !done_i);
  assign occ_d   = d_pend_q || ((state_q == BUSY_D) && !done_d);
  assign d_pulse = i_d_read || i_d_write;
  assign i_acc   = i_i_req && !occ_i;
  assign d_acc   = d_pulse && !occ_d;

  assign i_avail     = i_pend_q || i_acc;
  assign d_avail     = d_pend_q || d_acc;
  assign i_sel_addr  = i_pend_q ? i_addr_q : i_i_addr;
  assign d_sel_addr  = d_pend_q ? d_addr_q : i_d_addr;
  assign d_sel_we    = d_pend_q ? d_we_q : i_d_write;
  assign d_sel_wdata = d_pend_q ? d_wdata_q : (i_d_write ? i_d_wdata : '0);
  assign can_issue   = !busy || done;

  always_comb begin
    state_d   = state_q;
    i_pend_d  = i_pend_q;
    i_addr_d  = i_addr_q;
    d_pend_d  = d_pend_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    m_req_d   = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_valid_d = 1'b0;
    i_inst_d  = '0;
    d_valid_d = 1'b0;
    d_rdata_d = '0;
    err_d     = err_q;
    wd_clr    = 1'b0;

    if (busy && wd_hit && !i_m_valid) begin
      err_d[ERR_TIMEOUT] = 1'b1;
    end
    if ((i_i_req && occ_i) || (d_pulse && occ_d) || (i_d_read && i_d_write)) begin
      err_d[ERR_OVERRUN] = 1'b1;
    end

    if (i_acc) begin
      i_pend_d = 1'b1;
      i_addr_d = i_i_addr;
    end
    if (d_acc) begin
      d_pend_d  = 1'b1;
      d_we_d    = i_d_write;
      d_addr_d  = i_d_addr;
      d_wdata_d = i_d_write ? i_d_wdata : '0;
    end

    if (done_i) begin
      i_valid_d = 1'b1;
      i_inst_d  = i_m_valid ? i_m_rdata[INST_W-1:0] : '0;
    end
    if (done_d) begin
      d_valid_d = 1'b1;
      d_rdata_d = (i_m_valid && !m_we_q) ? i_m_rdata : '0;
    end
    if (done) begin
      state_d = IDLE;
    end

    if (can_issue) begin
      if (d_avail) begin
        state_d   = BUSY_D;
        m_req_d   = 1'b1;
        m_we_d    = d_sel_we;
        m_addr_d  = d_sel_addr;
        m_wdata_d = d_sel_wdata;
        d_pend_d  = 1'b0;
        wd_clr    = 1'b1;
      end else if (i_avail) begin
        state_d   = BUSY_I;
        m_req_d   = 1'b1;
        m_we_d    = 1'b0;
        m_addr_d  = i_sel_addr;
        m_wdata_d = '0;
        i_pend_d  = 1'b0;
        wd_clr    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      i_pend_q  <= 1'b0;
      i_addr_q  <= '0;
      d_pend_q  <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_valid_q <= 1'b0;
      i_inst_q  <= '0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_pend_q  <= i_pend_d;
      i_addr_q  <= i_addr_d;
      d_pend_q  <= d_pend_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_valid_q <= i_valid_d;
      i_inst_q  <= i_inst_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign o_m_req   = m_req_q;
  assign o_m_we    = m_we_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_wdata = m_wdata_q;
  assign o_i_valid = i_valid_q;
  assign o_i_inst  = i_inst_q;
  assign o_d_valid = d_valid_q;
  assign o_d_rdata = d_rdata_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus reset and read+write corner sequences.
// Each row's inputs are applied for one cycle; expected outputs are those visible after that clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_valid;
  logic [INST_W-1:0] i_inst;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_valid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_i_req   (i_req),
    .i_i_addr  (i_addr),
    .o_i_valid (i_valid),
    .o_i_inst  (i_inst),
    .i_d_read  (d_read),
    .i_d_write (d_write),
    .i_d_addr  (d_addr),
    .i_d_wdata (d_wdata),
    .o_d_valid (d_valid),
    .o_d_rdata (d_rdata),
    .o_m_req   (m_req),
    .o_m_we    (m_we),
    .o_m_addr  (m_addr),
    .o_m_wdata (m_wdata),
    .i_m_valid (m_valid),
    .i_m_rdata (m_rdata),
    .o_err     (err)
  );

  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        dr, dw;
    logic [63:0] da, dwd;
    logic        mv;
    logic [63:0] mrd;
    logic        e_mreq, e_mwe;
    logic [63:0] e_maddr, e_mwdata;
    logic        e_ival;
    logic [31:0] e_inst;
    logic        e_dval;
    logic [63:0] e_drdata;
    logic [1:0]  e_err;
  } vec_t;

  function automatic vec_t v(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                             input logic [63:0] da, input logic [63:0] dwd, input logic mv, input logic [63:0] mrd,
                             input logic emr, input logic emw, input logic [63:0] ema, input logic [63:0] emwd,
                             input logic eiv, input logic [31:0] ei, input logic edv, input logic [63:0] edr,
                             input logic [1:0] eer);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd; r.mv = mv; r.mrd = mrd;
    r.e_mreq = emr; r.e_mwe = emw; r.e_maddr = ema; r.e_mwdata = emwd;
    r.e_ival = eiv; r.e_inst = ei; r.e_dval = edv; r.e_drdata = edr; r.e_err = eer;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input string tag, input vec_t r);
    @(negedge clk);
    i_req = r.ir; i_addr = r.ia; d_read = r.dr; d_write = r.dw; d_addr = r.da; d_wdata = r.dwd;
    m_valid = r.mv; m_rdata = r.mrd;
    @(posedge clk);
    #1;
    chk({tag, ".m_req"},   64'(m_req),   64'(r.e_mreq));
    chk({tag, ".m_we"},    64'(m_we),    64'(r.e_mwe));
    chk({tag, ".m_addr"},  m_addr,       r.e_maddr);
    chk({tag, ".m_wdata"}, m_wdata,      r.e_mwdata);
    chk({tag, ".i_valid"}, 64'(i_valid), 64'(r.e_ival));
    chk({tag, ".i_inst"},  64'(i_inst),  64'(r.e_inst));
    chk({tag, ".d_valid"}, 64'(d_valid), 64'(r.e_dval));
    chk({tag, ".d_rdata"}, d_rdata,      r.e_drdata);
    chk({tag, ".err"},     64'(err),     64'(r.e_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".m_req"},   64'(m_req),   64'd0);
    chk({tag, ".m_we"},    64'(m_we),    64'd0);
    chk({tag, ".m_addr"},  m_addr,       64'd0);
    chk({tag, ".m_wdata"}, m_wdata,      64'd0);
    chk({tag, ".i_valid"}, 64'(i_valid), 64'd0);
    chk({tag, ".i_inst"},  64'(i_inst),  64'd0);
    chk({tag, ".d_valid"}, 64'(d_valid), 64'd0);
    chk({tag, ".d_rdata"}, d_rdata,      64'd0);
    chk({tag, ".err"},     64'(err),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    vec_t tbl[$];

    // Scenario A: single fetch, memory answers 3 cycles after o_m_req.
    tbl.push_back(v(1, 64'h40, 0, 0, 0, 0, 0, 0,                    1, 0, 64'h40, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h40, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h40, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h40, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h00A00093,              0, 0, 64'h40, 0, 1, 32'h00A00093, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h40, 0, 0, 0, 0, 0, 2'b00));
    // Scenario B: simultaneous fetch and load; load first, fetch issued back-to-back with o_d_valid.
    tbl.push_back(v(1, 64'h10, 1, 0, 64'h200, 0, 0, 0,              1, 0, 64'h200, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h200, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h1122334455667788,      1, 0, 64'h10, 0, 0, 0, 1, 64'h1122334455667788, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h10, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hFFFFFFFFCAFEBABE,      0, 0, 64'h10, 0, 1, 32'hCAFEBABE, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h10, 0, 0, 0, 0, 0, 2'b00));
    // Scenario C: store; write fields held until completion, response data 0.
    tbl.push_back(v(0, 0, 0, 1, 64'h208, 64'hDEADBEEF, 0, 0,        1, 1, 64'h208, 64'hDEADBEEF, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 1, 64'h208, 64'hDEADBEEF, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 1, 64'h208, 64'hDEADBEEF, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h1234,                  0, 1, 64'h208, 64'hDEADBEEF, 0, 0, 1, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 1, 64'h208, 64'hDEADBEEF, 0, 0, 0, 0, 2'b00));
    // Scenario D: silent memory, watchdog fires after 4 busy cycles; late response ignored.
    tbl.push_back(v(0, 0, 1, 0, 64'h300, 0, 0, 0,                   1, 0, 64'h300, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 1, 0, 2'b01));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h55,                    0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b01));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h300, 0, 0, 0, 0, 0, 2'b01));
    // Scenario E: second fetch while one is in flight is dropped; exactly one o_i_valid.
    tbl.push_back(v(1, 64'h80, 0, 0, 0, 0, 0, 0,                    1, 0, 64'h80, 0, 0, 0, 0, 0, 2'b01));
    tbl.push_back(v(1, 64'h84, 0, 0, 0, 0, 0, 0,                    0, 0, 64'h80, 0, 0, 0, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h80, 0, 0, 0, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h13,                    0, 0, 64'h80, 0, 1, 32'h13, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h80, 0, 0, 0, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h80, 0, 0, 0, 0, 0, 2'b11));
    // Scenario F: a fetch pulse coinciding with its own completion is accepted and issued at once.
    tbl.push_back(v(1, 64'h90, 0, 0, 0, 0, 0, 0,                    1, 0, 64'h90, 0, 0, 0, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'h90, 0, 0, 0, 0, 0, 2'b11));
    tbl.push_back(v(1, 64'hA0, 0, 0, 0, 0, 1, 64'h21,               1, 0, 64'hA0, 0, 1, 32'h21, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'h22,                    0, 0, 64'hA0, 0, 1, 32'h22, 0, 0, 2'b11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 64'hA0, 0, 0, 0, 0, 0, 2'b11));

    rst_n = 1'b0;
    i_req = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    m_valid = 0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply($sformatf("row%0d", k), tbl[k]);
    end

    // Asynchronous reset in the middle of a load; a late response must not surface.
    apply("rst.issue", v(0, 0, 1, 0, 64'h500, 0, 0, 0,    1, 0, 64'h500, 0, 0, 0, 0, 0, 2'b11));
    apply("rst.busy",  v(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 64'h500, 0, 0, 0, 0, 0, 2'b11));
    @(negedge clk);
    i_req = 0; d_read = 0; d_write = 0; m_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    apply("rst.late",  v(0, 0, 0, 0, 0, 0, 1, 64'h99,     0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    apply("rst.quiet", v(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    apply("rst.fetch", v(1, 64'hC0, 0, 0, 0, 0, 0, 0,     1, 0, 64'hC0, 0, 0, 0, 0, 0, 2'b00));
    apply("rst.resp",  v(0, 0, 0, 0, 0, 0, 1, 64'h33,     0, 0, 64'hC0, 0, 1, 32'h33, 0, 0, 2'b00));

    // Read and write together: issued as a write and flagged as overrun.
    apply("rw.issue",  v(0, 0, 1, 1, 64'h600, 64'hAB, 0, 0,  1, 1, 64'h600, 64'hAB, 0, 0, 0, 0, 2'b10));
    apply("rw.hold",   v(0, 0, 0, 0, 0, 0, 0, 0,             0, 1, 64'h600, 64'hAB, 0, 0, 0, 0, 2'b10));
    apply("rw.resp",   v(0, 0, 0, 0, 0, 0, 1, 64'h77,        0, 1, 64'h600, 64'hAB, 0, 0, 1, 0, 2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
